// File: rtl/irq_pending_ctrl_pkg.sv
// Shared constants, state encoding and priority helper for the interrupt
// pending front-end.
package irq_pending_ctrl_pkg;

    localparam int N_DEF  = 8;
    localparam int W_DEF  = 3;
    localparam int CW_DEF = 8;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_e;

    // MSB-first: a later (higher) set bit overrides any lower one.
    function automatic logic [W_DEF-1:0] idx_of_highest(input logic [N_DEF-1:0] vec);
        logic [W_DEF-1:0] idx;
        idx = {W_DEF{1'b0}};
        for (int i = 0; i < N_DEF; i++) begin
            idx = vec[i] ? W_DEF'(i) : idx;
        end
        return idx;
    endfunction

endpackage

// File: rtl/irq_pending_ctrl_prio_sel.sv
// Combinational MSB-first priority encoder with a valid flag.
module irq_pending_ctrl_prio_sel #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] idx,
    output logic         valid
);

    // Ascending scan so the highest set bit is the last to take effect.
    always_comb begin
        idx   = {W{1'b0}};
        valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            idx   = vec[i] ? W'(i) : idx;
            valid = valid | vec[i];
        end
    end

endmodule

// File: rtl/irq_pending_ctrl.sv
// Request front-end: edge detect, pending latch with mask, MSB-first grant
// over a valid/ack handshake, and a saturating count of lost edges.
module irq_pending_ctrl
    import irq_pending_ctrl_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int W  = W_DEF,
    parameter int CW = CW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [N-1:0]  irq_in,
    input  logic [N-1:0]  mask,
    output logic          req_valid,
    output logic [W-1:0]  req_id,
    input  logic          req_ack,
    output logic [N-1:0]  pending,
    output logic [CW-1:0] drop_cnt
);

    localparam int PW = $clog2(N + 1);

    state_e          state;
    logic [N-1:0]    irq_d;
    logic [N-1:0]    rise;
    logic [N-1:0]    clr;
    logic [N-1:0]    drops;
    logic [N-1:0]    cand;
    logic [W-1:0]    sel_id;
    logic            sel_valid;
    logic [PW-1:0]   drop_num;
    logic [CW+PW-1:0] cnt_sum;
    logic [CW-1:0]   cnt_next;

    assign rise  = irq_in & ~irq_d;
    assign cand  = pending & ~mask;
    // An edge landing on the bit being cleared re-arms it rather than dropping.
    assign drops = rise & pending & ~clr;

    irq_pending_ctrl_prio_sel #(
        .N(N),
        .W(W)
    ) u_prio_sel (
        .vec  (cand),
        .idx  (sel_id),
        .valid(sel_valid)
    );

    // One-hot clear of the acknowledged line.
    always_comb begin
        clr = {N{1'b0}};
        if (req_valid && req_ack) begin
            clr[req_id] = 1'b1;
        end else begin
            clr = {N{1'b0}};
        end
    end

    // Popcount of lost edges and saturating counter update.
    always_comb begin
        drop_num = {PW{1'b0}};
        for (int i = 0; i < N; i++) begin
            drop_num = drop_num + PW'(drops[i]);
        end
        cnt_sum = {{PW{1'b0}}, drop_cnt} + {{CW{1'b0}}, drop_num};
        if (cnt_sum > {{PW{1'b0}}, {CW{1'b1}}}) begin
            cnt_next = {CW{1'b1}};
        end else begin
            cnt_next = cnt_sum[CW-1:0];
        end
    end

    // Edge-detect history, pending latch and drop counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_d    <= {N{1'b0}};
            pending  <= {N{1'b0}};
            drop_cnt <= {CW{1'b0}};
        end else begin
            irq_d    <= irq_in;
            pending  <= (pending & ~clr) | rise;
            drop_cnt <= cnt_next;
        end
    end

    // Grant FSM; req_id is frozen for the whole PRESENT phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            req_valid <= 1'b0;
            req_id    <= {W{1'b0}};
        end else begin
            case (state)
                IDLE: begin
                    if (en && sel_valid) begin
                        state     <= PRESENT;
                        req_valid <= 1'b1;
                        req_id    <= sel_id;
                    end else begin
                        state     <= IDLE;
                        req_valid <= 1'b0;
                    end
                end
                PRESENT: begin
                    if (req_ack) begin
                        state     <= IDLE;
                        req_valid <= 1'b0;
                    end else begin
                        state     <= PRESENT;
                        req_valid <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
